sevenseg_scan_ctrl: RTL and testbench



---
 rtl/sevenseg_scan_ctrl_pkg.sv | 26 ++
 rtl/sevenseg_scan_ctrl_if.sv | 37 +++
 rtl/sevenseg_scan_ctrl_decode.sv | 19 +
 rtl/sevenseg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_scan_ctrl_pkg.sv
// ============================================================================
// Module  : sevenseg_pkg
// Brief   : Shared constants and hex font for the seven-segment scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sevenseg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t HEX_FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_if.sv
// ============================================================================
// Module  : sevenseg_scan_ctrl_if
// Brief   : Display-data and drive bundle between the debug mux and scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sevenseg_scan_ctrl_if
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS  = 8,
  parameter int PWM_BITS = 3
);

  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   dp;
  logic [NDIGITS-1:0]   digit_en;
  logic                 blank_lz;
  logic [PWM_BITS-1:0]  brightness;
  logic [NDIGITS-1:0]   an;
  logic [SEG_W-1:0]     sev_out;
  logic                 dp_out;
  logic                 frame_done;

  modport master (
    output value, dp, digit_en, blank_lz, brightness,
    input  an, sev_out, dp_out, frame_done
  );

  modport slave (
    input  value, dp, digit_en, blank_lz, brightness,
    output an, sev_out, dp_out, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_decode.sv
// ============================================================================
// Module  : sevenseg_decode
// Brief   : Combinational hex nibble to active-low segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_FONT[nibble];

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
// ============================================================================
// Module  : sevenseg_scan_ctrl
// Brief   : Multiplexed seven-segment scanner with blanking, PWM and snapshot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS        = 8,
  parameter int PWM_BITS       = 3,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_7seg,
  input  logic                Rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int                  IDX_W      = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(NDIGITS - 1);
  localparam logic [PWM_BITS-1:0] c_pwm_max  = '1;
  localparam logic [NDIGITS-1:0]  c_an_off   = AN_ACTIVE_LOW ? '1 : '0;
  localparam seg_t                c_seg_off  = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic                c_dp_off   = SEG_ACTIVE_LOW;

  logic [IDX_W-1:0]     r_digit_idx;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [4*NDIGITS-1:0] r_sh_value;
  logic [NDIGITS-1:0]   r_sh_dp;
  logic [NDIGITS-1:0]   r_sh_en;
  logic                 r_sh_blz;
  logic [PWM_BITS-1:0]  r_sh_bright;
  logic [NDIGITS-1:0]   r_an;
  seg_t                 r_sev;
  logic                 r_dp;

  logic                 w_frame_end;
  logic [3:0]           w_nibble;
  seg_t                 w_font;
  logic [NDIGITS-1:0]   w_lz;
  logic                 w_zero_run;
  logic                 w_lit;
  logic [NDIGITS-1:0]   w_an_nxt;
  seg_t                 w_sev_nxt;
  logic                 w_dp_nxt;

  assign w_frame_end = (r_digit_idx == c_last_idx) && (r_pwm_cnt == c_pwm_max);
  assign w_nibble    = r_sh_value[{r_digit_idx, 2'b00} +: 4];

  sevenseg_decode u_decode (
    .nibble (w_nibble),
    .seg    (w_font)
  );

  // w_lz[i]: every nibble and dp bit from digit i up to the top is zero.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_sh_value[4*i +: 4] == 4'h0) & ~r_sh_dp[i];
      w_lz[i]    = w_zero_run;
    end
  end

  always_comb begin
    w_lit = r_sh_en[r_digit_idx]
          && !(r_sh_blz && (r_digit_idx != '0) && w_lz[r_digit_idx])
          && (r_pwm_cnt <= r_sh_bright);
    w_an_nxt  = c_an_off;
    w_sev_nxt = c_seg_off;
    w_dp_nxt  = c_dp_off;
    if (w_lit) begin
      w_an_nxt  = NDIGITS'(1) << r_digit_idx;
      if (AN_ACTIVE_LOW) w_an_nxt = ~w_an_nxt;
      w_sev_nxt = SEG_ACTIVE_LOW ? w_font : ~w_font;
      w_dp_nxt  = SEG_ACTIVE_LOW ? ~r_sh_dp[r_digit_idx] : r_sh_dp[r_digit_idx];
    end
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
      r_an        <= c_an_off;
      r_sev       <= c_seg_off;
      r_dp        <= c_dp_off;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == c_pwm_max)
        r_digit_idx <= (r_digit_idx == c_last_idx) ? '0 : r_digit_idx + 1'b1;
      r_an  <= w_an_nxt;
      r_sev <= w_sev_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  // Last digit of the frame is still built from the old shadow on this edge.
  always_ff @(posedge clk_7seg) begin
    if (Rst || w_frame_end) begin
      r_sh_value  <= bus.value;
      r_sh_dp     <= bus.dp;
      r_sh_en     <= bus.digit_en;
      r_sh_blz    <= bus.blank_lz;
      r_sh_bright <= bus.brightness;
    end
  end

  assign bus.an         = r_an;
  assign bus.sev_out    = r_sev;
  assign bus.dp_out     = r_dp;
  assign bus.frame_done = w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
// ============================================================================
// Module  : tb_sevenseg_scan_ctrl
// Brief   : Frame-level scoreboard bench for the seven-segment scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_scan_ctrl;

  localparam int ND = 8;
  localparam int PB = 3;
  localparam int NV = 10;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        blz;
    logic [2:0]  br;
  } cfg_t;

  typedef struct {
    cfg_t        cfg;
    int          probe;
    logic [6:0]  probe_seg;
    int          probe_lit;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] sev;
    logic       dp;
  } exp_t;

  logic clk_7seg = 1'b0;
  logic Rst      = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vt [NV];

  always #5 clk_7seg = ~clk_7seg;

  sevenseg_scan_ctrl_if #(.NDIGITS(ND), .PWM_BITS(PB)) bus ();

  sevenseg_scan_ctrl #(
    .NDIGITS        (ND),
    .PWM_BITS       (PB),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_7seg (clk_7seg),
    .Rst      (Rst),
    .bus      (bus)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic cfg_t mk(input logic [31:0] v, input logic [7:0] d,
                              input logic [7:0] e, input logic b, input logic [2:0] r);
    cfg_t c;
    c.value = v; c.dp = d; c.en = e; c.blz = b; c.br = r;
    return c;
  endfunction

  function automatic vec_t mkv(input cfg_t c, input int p, input logic [6:0] s, input int l);
    vec_t v;
    v.cfg = c; v.probe = p; v.probe_seg = s; v.probe_lit = l;
    return v;
  endfunction

  // Expected drive for tick j of a frame scanned from snapshot c.
  function automatic exp_t model(input cfg_t c, input int j);
    exp_t e;
    int   d = j / 8;
    int   p = j % 8;
    bit   blank, lit;
    blank = c.blz && (d > 0) && ((c.value >> (4*d)) == 32'd0) && ((c.dp >> d) == 8'd0);
    lit   = c.en[d] && !blank && (p <= int'(c.br));
    e.an  = lit ? ~(8'd1 << d) : 8'hFF;
    e.sev = lit ? font(c.value[4*d +: 4]) : 7'h7F;
    e.dp  = lit ? ~c.dp[d] : 1'b1;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input cfg_t c);
    for (int j = 0; j < 64; j++) sb.push_back(model(c, j));
  endtask

  task automatic drive(input cfg_t c);
    bus.value      = c.value;
    bus.dp         = c.dp;
    bus.digit_en   = c.en;
    bus.blank_lz   = c.blz;
    bus.brightness = c.br;
    push_frame(c);
  endtask

  task automatic tick();
    @(posedge clk_7seg);
    @(negedge clk_7seg);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_an"},  32'(bus.an),         32'hFF);
    check({nm, "_sev"}, 32'(bus.sev_out),    32'h7F);
    check({nm, "_dp"},  32'(bus.dp_out),     32'h1);
    check({nm, "_fd"},  32'(bus.frame_done), 32'h0);
  endtask

  task automatic step(input int j);
    exp_t e;
    tick();
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("scan", {16'd0, bus.an, bus.sev_out, bus.dp_out}, {16'd0, e.an, e.sev, e.dp});
    end
    check("frame_done", 32'(bus.frame_done), 32'(j == 62));
  endtask

  task automatic run_frame(input vec_t v, input bit do_drive, input int drive_at, input cfg_t nxt);
    int lit = 0;
    for (int j = 0; j < 64; j++) begin
      step(j);
      if ((j / 8) == v.probe && bus.an != 8'hFF) begin
        lit++;
        check("probe_seg", 32'(bus.sev_out), 32'(v.probe_seg));
      end
      if (do_drive && j == drive_at) drive(nxt);
    end
    check("probe_lit", lit, v.probe_lit);
  endtask

  initial begin
    cfg_t c11, c22, crs;
    c11 = mk(32'h11111111, 8'h00, 8'hFF, 1'b0, 3'd7);
    c22 = mk(32'h22222222, 8'h00, 8'hFF, 1'b0, 3'd7);
    crs = mk(32'h12345678, 8'h00, 8'h0F, 1'b0, 3'd7);

    vt[0] = mkv(mk(32'h12345678, 8'h00, 8'hFF, 1'b0, 3'd7), 0, 7'b0000000, 8);
    vt[1] = mkv(mk(32'h12345678, 8'h00, 8'hFF, 1'b0, 3'd7), 7, 7'b1001111, 8);
    vt[2] = mkv(mk(32'h000000A0, 8'h00, 8'hFF, 1'b1, 3'd7), 1, 7'b0001000, 8);
    vt[3] = mkv(mk(32'h000000A0, 8'h00, 8'hFF, 1'b1, 3'd7), 3, 7'b1111111, 0);
    vt[4] = mkv(mk(32'h000000A0, 8'h10, 8'hFF, 1'b1, 3'd7), 4, 7'b0000001, 8);
    vt[5] = mkv(mk(32'h000000A0, 8'h10, 8'hFF, 1'b1, 3'd7), 5, 7'b1111111, 0);
    vt[6] = mkv(mk(32'h12345678, 8'h00, 8'hFF, 1'b0, 3'd0), 2, 7'b0100000, 1);
    vt[7] = mkv(mk(32'h12345678, 8'h00, 8'hFF, 1'b0, 3'd3), 5, 7'b0000110, 4);
    vt[8] = mkv(mk(32'h00000000, 8'h00, 8'hFF, 1'b1, 3'd7), 0, 7'b0000001, 8);
    vt[9] = mkv(mk(32'hFEDCBA98, 8'h00, 8'h5A, 1'b0, 3'd7), 1, 7'b0000100, 8);

    // Reset held three ticks; shadow follows the live inputs meanwhile.
    drive(vt[0].cfg);
    repeat (3) tick();
    check_reset_outputs("reset");
    Rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_frame(vt[i], 1'b1, 0, (i < NV - 1) ? vt[i+1].cfg : c11);

    // Mid-frame change while digit 3 scans must wait for the next snapshot.
    run_frame(mkv(c11, 5, 7'b1001111, 8), 1'b1, 24, c22);
    run_frame(mkv(c22, 7, 7'b0010010, 8), 1'b1, 0, crs);

    // Reset lands with digit 5, pwm 4 in the counters.
    for (int j = 0; j < 44; j++) step(j);
    Rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    sb.delete();
    tick();
    Rst = 1'b0;
    push_frame(crs);
    run_frame(mkv(crs, 4, 7'b1111111, 0), 1'b0, -1, crs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
